// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell is reused over WIDTH cycles, LSB first.
// Optional signed-overflow flag is built only when SERIAL_ADD_OVF_EN is defined.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .c_in (carry),
    .s    (fa_s),
    .c_out(fa_c)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at position 0.
  assign res_next = (res_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      count  <= '0;
      carry  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= fa_c;
          count  <= count + CW'(1);
          if (count == LAST) begin
            sum   <= res_next;
            c_out <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB during the final bit
            ovf   <= carry ^ fa_c;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): scoreboard of expected
// {sum,c_out,ovf} checked on every done pulse, plus per-scenario timing checks.

module tb_serial_add_ctrl;

  localparam int  WIDTH  = 8;
  localparam time PERIOD = 10;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             c_in  = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   total      = 0;
  int   bad        = 0;
  int   done_count = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out),
    .ovf  (ovf)
  );

  always #(PERIOD / 2) clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    exp_t        e;
    logic [WIDTH:0] r;
    r       = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    e.sum   = r[WIDTH-1:0];
    e.c_out = r[WIDTH];
`ifdef SERIAL_ADD_OVF_EN
    e.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
`else
    e.ovf   = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_done: got sum=%h c_out=%b ovf=%b, required no done pulse",
                 sum, c_out, ovf);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({sum, c_out, ovf} !== {e.sum, e.c_out, e.ovf}) begin
          bad++;
          $display("[TB] FAIL result: got sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                   sum, c_out, ovf, e.sum, e.c_out, e.ovf);
        end
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL busy_in_done: got busy=%b, required 0", busy);
      end
    end
  end

  // Called just after a posedge with the DUT in IDLE; accepts at the next edge.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    a        = x;
    b        = y;
    c_in     = ci;
    start    = 1'b1;
    last_exp = model(x, y, ci);
    sb.push_back(last_exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    c_in  = 1'($urandom);
  endtask

  task automatic wait_done(input string name, output time t);
    logic seen;
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        t    = $time;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got no done within 40 cycles, required a done pulse", name);
    end
  endtask

  task automatic check_hold(input string name);
    repeat (3) @(negedge clk);
    total++;
    if ({sum, c_out, ovf, busy, done} !== {last_exp.sum, last_exp.c_out, last_exp.ovf, 2'b00}) begin
      bad++;
      $display("[TB] FAIL %s_hold: got sum=%h c_out=%b ovf=%b busy=%b done=%b, required sum=%h c_out=%b ovf=%b idle",
               name, sum, c_out, ovf, busy, done, last_exp.sum, last_exp.c_out, last_exp.ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, sum, c_out, ovf} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b sum=%h c_out=%b ovf=%b, required all 0",
               busy, done, sum, c_out, ovf);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_timing();
    issue(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL timing_run%0d: got busy=%b done=%b, required busy=1 done=0", i, busy, done);
      end
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL timing_done: got busy=%b done=%b, required busy=0 done=1", busy, done);
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL timing_after: got busy=%b done=%b, required busy=0 done=0", busy, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    logic [WIDTH-1:0] xs[4] = '{8'hFF, 8'hA5, 8'h7F, 8'h80};
    logic [WIDTH-1:0] ys[4] = '{8'h01, 8'h5A, 8'h01, 8'h80};
    logic             cs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    time t;
    for (int i = 0; i < 4; i++) begin
      issue(xs[i], ys[i], cs[i]);
      wait_done("arith", t);
      check_hold("arith");
    end
    for (int i = 0; i < 4; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_done("random", t);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    time t;
    int  dc;
    issue(8'h03, 8'h04, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", t);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc    = done_count;
    repeat (15) @(negedge clk);
    total++;
    if (done_count != dc || sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL ignore_extra: got %0d extra done, %0d pending, required 0 and 0",
               done_count - dc, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    time t;
    int  dc;
    issue(8'h0F, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, c_out, ovf} !== '0) begin
      bad++;
      $display("[TB] FAIL midrst_outputs: got busy=%b done=%b sum=%h c_out=%b ovf=%b, required all 0",
               busy, done, sum, c_out, ovf);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dc    = done_count;
    repeat (15) @(negedge clk);
    total++;
    if (done_count != dc) begin
      bad++;
      $display("[TB] FAIL midrst_nodone: got %0d done pulses, required 0", done_count - dc);
    end
    @(posedge clk);
    #1;
    issue(8'h0F, 8'h01, 1'b0);
    wait_done("midrst_fresh", t);
    check_hold("midrst_fresh");
  endtask

  task automatic test_back_to_back();
    time t;
    time prev;
    int  dc;
    prev     = 0;
    a        = 8'h10;
    b        = 8'h20;
    c_in     = 1'b0;
    start    = 1'b1;
    last_exp = model(8'h10, 8'h20, 1'b0);
    sb.push_back(last_exp);
    for (int k = 0; k < 3; k++) begin
      wait_done("b2b", t);
      if (k > 0) begin
        total++;
        if (t - prev != 10 * PERIOD) begin
          bad++;
          $display("[TB] FAIL b2b_period: got %0t between done pulses, required %0t", t - prev,
                   10 * PERIOD);
        end
      end
      prev = t;
      if (k < 2) sb.push_back(last_exp);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    dc = done_count;
    repeat (12) @(negedge clk);
    total++;
    if (done_count != dc || sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL b2b_tail: got %0d extra done, %0d pending, required 0 and 0",
               done_count - dc, sb.size());
    end
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_timing();
    test_arith();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that reuses a single `full_adder` cell (ports x, y, c_in, s, c_out) over WIDTH clock cycles to add two WIDTH-bit operands. It sequences LSB-first operand bits into the cell and registers the carry between cycles. It shifts sum bits into a result register. It uses a start/busy/done handshake toward the host logic.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
c_in  input  1  carry-in; captured on accepted start
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  one-cycle pulse: sum/c_out valid
sum  output  WIDTH  result; holds last completed value
c_out  output  1  final carry; holds last completed value
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- rst_n low (async) forces state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, bit counter=0, carry reg=0, operand shift regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1: load shift regs A<=a and B<=b, load carry reg<=c_in, set count<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: the full_adder cell sees x=A[0], y=B[0], c_in=carry reg. Each edge:
  - A and B shift right by 1.
  - Result shift reg shifts right with cell s entering at the MSB.
  - carry reg<=cell c_out.
  - count increments.
  - On the edge where count==WIDTH-1, the last bit is processed. That edge loads sum<=completed result and c_out<=cell c_out, then goes to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- busy=1 exactly in RUN (WIDTH cycles). done=0 outside DONE.
- Latency: start accepted at edge E. busy is high in cycles E+1..E+WIDTH. done is high in cycle E+WIDTH+1. Earliest next accepted start is edge E+WIDTH+2.
- start while in RUN or DONE: ignored, with no effect on the current operation. a/b/c_in changes after capture: no effect.
- sum/c_out/ovf update only at RUN→DONE and otherwise hold their value, including across IDLE.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); unsigned.
- Reset mid-RUN: operation abandoned; all outputs to reset values immediately; no done pulse.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN
- Defined: ovf is loaded at the RUN→DONE transition with (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow. The carry into the MSB is the carry reg value during the final RUN cycle. ovf holds like sum.
- Not defined: ovf is tied to constant 0; no extra registers are built. The port list is unchanged.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, c_in=0, start pulse at edge E → busy high cycles E+1..E+8; done high only in cycle E+9; sum=0x00, c_out=0, ovf=0.
- a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, ovf=0. Also a=0xA5, b=0x5A, c_in=1 → sum=0x00, c_out=1.
- With SERIAL_ADD_OVF_EN, a=0x7F, b=0x01, c_in=0 → sum=0x80, c_out=0, ovf=1. Without the macro, same stimulus → ovf=0.
- Start with a=0x03, b=0x04, then assert start with a=0xFF, b=0xFF at E+3 and again in DONE → both ignored; result sum=0x07, c_out=0; single done pulse.
- Start with a=0x0F, b=0x01; drop rst_n at E+4 for 1 cycle → busy=0, done=0, sum=0 immediately; no done pulse follows. A fresh start then completes normally with sum=0x10.
- Back-to-back: start held high continuously with a=0x10, b=0x20 → done pulses every 10 cycles; sum=0x30 each time; no start accepted in RUN/DONE.
